// File: rtl/key_pkg.sv
// Shared encodings for the key event path: event types and per-key FSM states.
package key_pkg;
  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_type_e;

  typedef enum logic [1:0] {
    KS_IDLE      = 2'd0,
    KS_HELD      = 2'd1,
    KS_LONG_HELD = 2'd2
  } key_state_e;
endpackage

// File: rtl/key_fsm.sv
// Single-key hold-timer FSM: turns a debounced level into one-cycle event pulses.
module key_fsm
  import key_pkg::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int REPEAT_EN     = 1,
  parameter int CNT_W         = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_i,
  output logic       evt_o,
  output logic [1:0] evt_type_o
);
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= KS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // In HELD the counter holds the number of held edges since PRESS, so LONG
  // lands exactly LONG_CYCLES edges after PRESS.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    evt_o      = 1'b0;
    evt_type_o = EVT_PRESS;
    case (state_q)
      KS_IDLE: if (key_i) begin
        state_d = KS_HELD;
        evt_o   = 1'b1;
        cnt_d   = CNT_W'(1);
      end
      KS_HELD: begin
        if (!key_i) begin
          state_d    = KS_IDLE;
          evt_o      = 1'b1;
          evt_type_o = EVT_RELEASE;
          cnt_d      = '0;
        end else if (cnt_q == CNT_W'(LONG_CYCLES)) begin
          state_d    = KS_LONG_HELD;
          evt_o      = 1'b1;
          evt_type_o = EVT_LONG;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      KS_LONG_HELD: begin
        if (!key_i) begin
          state_d    = KS_IDLE;
          evt_o      = 1'b1;
          evt_type_o = EVT_RELEASE;
          cnt_d      = '0;
        end else if (REPEAT_EN != 0) begin
          if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
            evt_o      = 1'b1;
            evt_type_o = EVT_REPEAT;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = KS_IDLE;
    endcase
  end
endmodule

// File: rtl/key_event.sv
// Key event generator: per-key FSMs, one-entry pending slots, fixed-priority
// arbiter and a first-word-fall-through event FIFO drained by valid/ready.
module key_event
  import key_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int REPEAT_EN     = 1,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_W         = 32,
  localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [KW-1:0]     evt_key,
  output logic [1:0]        evt_type,
  output logic [AW:0]       evt_count,
  output logic              ovf,
  input  logic              ovf_clr
);
  logic [N_KEYS-1:0]      gen_evt;
  logic [N_KEYS-1:0][1:0] gen_type;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_fsm #(
      .LONG_CYCLES(LONG_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN(REPEAT_EN), .CNT_W(CNT_W)
    ) u_fsm (
      .clk(clk), .rst_n(reset_n), .key_i(key_in[g]),
      .evt_o(gen_evt[g]), .evt_type_o(gen_type[g])
    );
  end

  logic [N_KEYS-1:0]          pend_vld_q, pend_vld_d;
  logic [N_KEYS-1:0][1:0]     pend_type_q, pend_type_d;
  logic [FIFO_DEPTH-1:0][KW-1:0] fifo_key_q;
  logic [FIFO_DEPTH-1:0][1:0]    fifo_type_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [KW-1:0] sel;
  logic          any_pend, full, push, pop, drop;

  assign evt_valid = (count_q != '0);
  assign evt_key   = fifo_key_q[rd_ptr_q];
  assign evt_type  = fifo_type_q[rd_ptr_q];
  assign evt_count = count_q;
  assign ovf       = ovf_q;
  assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop       = evt_valid & evt_ready;
  assign push      = any_pend & (~full | pop);

  // Lowest-index pending slot wins.
  always_comb begin
    sel      = '0;
    any_pend = 1'b0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pend_vld_q[i]) begin
        sel      = KW'(i);
        any_pend = 1'b1;
      end
    end
  end

  // A slot freed by this edge's push may take a new event without overflow.
  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_type_d = pend_type_q;
    drop        = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (push && sel == KW'(i)) pend_vld_d[i] = 1'b0;
      if (gen_evt[i]) begin
        if (pend_vld_q[i] && !(push && sel == KW'(i))) begin
          drop = 1'b1;
        end else begin
          pend_vld_d[i]  = 1'b1;
          pend_type_d[i] = gen_type[i];
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
    ovf_d = (ovf_q & ~ovf_clr) | drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld_q  <= '0;
      pend_type_q <= '0;
      fifo_key_q  <= '0;
      fifo_type_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_type_q <= pend_type_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      if (push) begin
        fifo_key_q[wr_ptr_q]  <= sel;
        fifo_type_q[wr_ptr_q] <= pend_type_q[sel];
        wr_ptr_q              <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end
endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: LONG=8, REPEAT=4, FIFO depth 4; a second
// instance with REPEAT_EN=0 shares all inputs.
module tb_key_event;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key_in;
  logic       evt_ready, ovf_clr;
  logic       evt_valid, ovf, evt_valid2, ovf2;
  logic [1:0] evt_key, evt_type, evt_key2, evt_type2;
  logic [2:0] evt_count, evt_count2;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int ev_key[$], ev_type[$], ev_cyc[$];
  int ev2_key[$], ev2_type[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_event #(.N_KEYS(4), .LONG_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(1),
              .FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .key_in(key_in), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_key(evt_key), .evt_type(evt_type),
    .evt_count(evt_count), .ovf(ovf), .ovf_clr(ovf_clr));

  key_event #(.N_KEYS(4), .LONG_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(0),
              .FIFO_DEPTH(4), .CNT_W(8)) dut_nr (
    .clk(clk), .reset_n(reset_n), .key_in(key_in), .evt_valid(evt_valid2),
    .evt_ready(evt_ready), .evt_key(evt_key2), .evt_type(evt_type2),
    .evt_count(evt_count2), .ovf(ovf2), .ovf_clr(ovf_clr));

  // Record each accepted event (sampled mid-cycle, accepted on the next edge).
  always @(negedge clk) begin
    if (reset_n && evt_valid && evt_ready) begin
      ev_key.push_back(int'(evt_key));
      ev_type.push_back(int'(evt_type));
      ev_cyc.push_back(cyc);
    end
    if (reset_n && evt_valid2 && evt_ready) begin
      ev2_key.push_back(int'(evt_key2));
      ev2_type.push_back(int'(evt_type2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_ev(input string tag, input int idx, input int k, input int t);
    if (idx < ev_key.size()) begin
      chk({tag, "_key"}, ev_key[idx], k);
      chk({tag, "_type"}, ev_type[idx], t);
    end else begin
      chk({tag, "_missing"}, ev_key.size(), idx + 1);
    end
  endtask

  task automatic chk_ev2(input string tag, input int idx, input int t);
    if (idx < ev2_key.size()) chk({tag, "_type"}, ev2_type[idx], t);
    else chk({tag, "_missing"}, ev2_key.size(), idx + 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; key_in = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    ev_key.delete(); ev_type.delete(); ev_cyc.delete();
    ev2_key.delete(); ev2_type.delete();
  endtask

  initial begin
    reset_n = 1'b0; key_in = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
    tick();
    chk("rst_valid", evt_valid, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_key",   evt_key, 0);
    chk("rst_type",  evt_type, 0);
    chk("rst_ovf",   ovf, 0);

    // 1: short press on key 1
    do_reset();
    key_in = 4'b0010;
    tick();
    chk("s1_valid_T", evt_valid, 0);
    tick();
    chk("s1_valid_T1", evt_valid, 1);
    chk("s1_head_key", evt_key, 1);
    chk("s1_head_type", evt_type, 0);
    chk("s1_count", evt_count, 1);
    tick();
    key_in = 4'b0000;
    ticks(6);
    chk("s1_n_events", ev_key.size(), 2);
    chk_ev("s1_e0", 0, 1, 0);
    chk_ev("s1_e1", 1, 1, 1);
    chk("s1_ovf", ovf, 0);

    // 2: key 0 held 20 edges, with and without REPEAT
    do_reset();
    key_in = 4'b0001;
    ticks(20);
    key_in = 4'b0000;
    ticks(6);
    chk("s2_n_events", ev_key.size(), 5);
    chk_ev("s2_press", 0, 0, 0);
    chk_ev("s2_long",  1, 0, 2);
    chk_ev("s2_rep1",  2, 0, 3);
    chk_ev("s2_rep2",  3, 0, 3);
    chk_ev("s2_rel",   4, 0, 1);
    if (ev_cyc.size() >= 4) begin
      chk("s2_long_gap", ev_cyc[1] - ev_cyc[0], 8);
      chk("s2_rep1_gap", ev_cyc[2] - ev_cyc[1], 4);
      chk("s2_rep2_gap", ev_cyc[3] - ev_cyc[2], 4);
    end
    chk("s2nr_n_events", ev2_key.size(), 3);
    chk_ev2("s2nr_press", 0, 0);
    chk_ev2("s2nr_long",  1, 2);
    chk_ev2("s2nr_rel",   2, 1);

    // 3: all keys on one edge drain in index order on consecutive cycles
    do_reset();
    key_in = 4'b1111;
    ticks(5);
    key_in = 4'b0000;
    ticks(10);
    chk("s3_n_events", ev_key.size(), 8);
    for (int k = 0; k < 4; k++) chk_ev($sformatf("s3_p%0d", k), k, k, 0);
    for (int k = 0; k < 4; k++) chk_ev($sformatf("s3_r%0d", k), k + 4, k, 1);
    if (ev_cyc.size() >= 4)
      for (int k = 1; k < 4; k++) chk($sformatf("s3_gap%0d", k), ev_cyc[k] - ev_cyc[0], k);

    // 4/5: backpressure, pending slots, overflow, full-FIFO push+pop
    do_reset();
    evt_ready = 1'b0;
    key_in = 4'b1111;
    ticks(5);
    chk("s4_full_count", evt_count, 4);
    key_in = 4'b0000;
    tick();
    chk("s4_no_ovf_yet", ovf, 0);
    key_in = 4'b0001;
    tick();
    chk("s4_count_held", evt_count, 4);
    chk("s4_ovf_set", ovf, 1);
    chk("s4_head_key", evt_key, 0);
    chk("s4_head_type", evt_type, 0);
    key_in = 4'b0000; ovf_clr = 1'b1;
    tick();
    chk("s4_set_wins", ovf, 1);
    evt_ready = 1'b1;
    tick();
    chk("s5_count_stays", evt_count, 4);
    chk("s5_ovf_cleared", ovf, 0);
    ovf_clr = 1'b0;
    ticks(10);
    chk("s4_n_events", ev_key.size(), 8);
    for (int k = 0; k < 4; k++) chk_ev($sformatf("s4_p%0d", k), k, k, 0);
    for (int k = 0; k < 4; k++) chk_ev($sformatf("s4_r%0d", k), k + 4, k, 1);
    chk("s4_drained", evt_count, 0);
    chk("s5_no_drop", ovf, 0);

    // 6: async reset mid-hold, key 2 still held afterwards
    do_reset();
    evt_ready = 1'b0;
    key_in = 4'b0111;
    ticks(4);
    chk("s6_queued", evt_count, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_rst_valid", evt_valid, 0);
    chk("s6_rst_count", evt_count, 0);
    tick();
    key_in = 4'b0100; evt_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    chk("s6_valid_T", evt_valid, 0);
    tick();
    chk("s6_valid_T1", evt_valid, 1);
    chk("s6_key", evt_key, 2);
    chk("s6_type", evt_type, 0);
    chk("s6_ovf", ovf, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
